// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, FSM state type and one-hot helper for octal_request_arbiter
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/octal_request_arbiter_if.sv
// rtl/octal_request_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface octal_request_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (output req, input grant, input grant_idx, input grant_valid, input timeout);
  modport slave  (input req, output grant, output grant_idx, output grant_valid, output timeout);

endinterface

// File: rtl/arb_priority_pick.sv
// rtl/arb_priority_pick.sv - 8->3 priority encoder, highest rotated position wins
// Request vector is rotated by i_rot before encoding and the index is rotated back afterwards.
module arb_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_enc;

  // w_rot[j] = i_req[(j + i_rot) mod 8], so position 7 maps to index i_rot-1
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[{1'b0, i_rot} +: N_REQ];

  always_comb begin
    w_enc = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_rot[j]) w_enc = IDX_W'(j);
    end
  end

  assign o_any = |i_req;
  assign o_idx = w_enc + i_rot;

endmodule

// File: rtl/octal_request_arbiter.sv
// rtl/octal_request_arbiter.sv - 8-way arbiter with hold timeout and release gap
// ROUND_ROBIN_EN: rotate priority so the last granted index becomes lowest.
module octal_request_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
)
(
  input  logic                         clk,
  input  logic                         rst,
  octal_request_arbiter_if.slave       bus
);

  localparam int CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [IDX_W-1:0] w_rot;
  logic [IDX_W-1:0] w_win;
  logic             w_any;

  arb_priority_pick u_pick (
    .i_req (bus.req),
    .i_rot (w_rot),
    .o_idx (w_win),
    .o_any (w_any)
  );

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_ptr <= w_win;
    end
  end

  assign w_rot = r_ptr;
`else
  assign w_rot = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = '0;
    w_idx_nxt     = '0;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = onehot(w_win);
          w_idx_nxt   = w_win;
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        // a dropped request wins over a simultaneous expiry
        if (!bus.req[r_idx]) begin
          w_state_nxt = ST_GAP;
        end else if ((HOLD_MAX != 0) && (r_cnt == HOLD_LAST)) begin
          w_state_nxt   = ST_GAP;
          w_timeout_nxt = 1'b1;
        end else begin
          w_grant_nxt = r_grant;
          w_idx_nxt   = r_idx;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_idx;
  assign bus.grant_valid = r_valid;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_octal_request_arbiter.sv
// tb/tb_octal_request_arbiter.sv - scoreboard bench: HOLD_MAX=4 instance and HOLD_MAX=2 instance
module tb_octal_request_arbiter;

  typedef struct {
    bit rel;
    int idx;
    bit to;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  ev_t  qa[$];
  ev_t  qb[$];
  bit   pva;
  bit   pvb;

  octal_request_arbiter_if ifa ();
  octal_request_arbiter_if ifb ();

  octal_request_arbiter #(.HOLD_MAX(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  octal_request_arbiter #(.HOLD_MAX(2)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input string tag, input ev_t e, input bit rel_act,
                         input logic [7:0] g, input logic [2:0] idx, input logic to);
    logic [7:0] exp_g;
    chk({tag, "_kind"}, int'(rel_act), int'(e.rel));
    chk({tag, "_cycle"}, cyc, e.cyc);
    if (e.rel) begin
      chk({tag, "_rel_grant"}, int'(g), 0);
      chk({tag, "_rel_idx"}, int'(idx), 0);
      chk({tag, "_rel_timeout"}, int'(to), int'(e.to));
    end else begin
      exp_g = 8'd1 << e.idx;
      chk({tag, "_gnt_idx"}, int'(idx), e.idx);
      chk({tag, "_gnt_onehot"}, int'(g), int'(exp_g));
      chk({tag, "_gnt_timeout"}, int'(to), 0);
    end
  endtask

  task automatic unexpected(input string tag, input int v);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none (cycle %0d)", tag, v, cyc);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      pva = 1'b0;
    end else begin
      if (ifa.grant_valid != pva) begin
        if (qa.size() == 0) unexpected("a_unexpected_event", int'(ifa.grant_valid));
        else begin
          e = qa.pop_front();
          compare("a", e, !ifa.grant_valid, ifa.grant, ifa.grant_idx, ifa.timeout);
        end
      end else if (ifa.timeout) begin
        unexpected("a_stray_timeout", 1);
      end
      pva = ifa.grant_valid;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      pvb = 1'b0;
    end else begin
      if (ifb.grant_valid != pvb) begin
        if (qb.size() == 0) unexpected("b_unexpected_event", int'(ifb.grant_valid));
        else begin
          e = qb.pop_front();
          compare("b", e, !ifb.grant_valid, ifb.grant, ifb.grant_idx, ifb.timeout);
        end
      end else if (ifb.timeout) begin
        unexpected("b_stray_timeout", 1);
      end
      pvb = ifb.grant_valid;
    end
  end

  initial begin
    int c;
    int s;
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    ifa.req = '0;
    ifb.req = '0;
    repeat (3) @(negedge clk);
    chk("reset_grant", int'(ifa.grant), 0);
    chk("reset_idx", int'(ifa.grant_idx), 0);
    chk("reset_valid", int'(ifa.grant_valid), 0);
    chk("reset_timeout", int'(ifa.timeout), 0);
    chk("reset_b_valid", int'(ifb.grant_valid), 0);
    rst = 1'b0;

    // no requests: nothing may be granted
    repeat (5) begin
      @(negedge clk);
      chk("idle_valid", int'(ifa.grant_valid), 0);
      chk("idle_grant", int'(ifa.grant), 0);
    end

    // 7 absent, 6 beats 2 and 1; after 6 drops, gap then 2
    c = cyc;
    ifa.req = 8'b0100_0110;
    qa.push_back('{rel: 1'b0, idx: 6, to: 1'b0, cyc: c + 1});
    repeat (2) @(negedge clk);
    ifa.req = 8'b0000_0110;
    qa.push_back('{rel: 1'b1, idx: 0, to: 1'b0, cyc: c + 3});
    qa.push_back('{rel: 1'b0, idx: 2, to: 1'b0, cyc: c + 5});
    repeat (3) @(negedge clk);
    ifa.req = '0;
    qa.push_back('{rel: 1'b1, idx: 0, to: 1'b0, cyc: c + 6});
    repeat (3) @(negedge clk);

    // HOLD_MAX=4 forced release, re-grant, then drop coinciding with expiry
    c = cyc;
    ifa.req = 8'b1000_0000;
    qa.push_back('{rel: 1'b0, idx: 7, to: 1'b0, cyc: c + 1});
    qa.push_back('{rel: 1'b1, idx: 0, to: 1'b1, cyc: c + 5});
    qa.push_back('{rel: 1'b0, idx: 7, to: 1'b0, cyc: c + 7});
    repeat (10) @(negedge clk);
    ifa.req = '0;
    qa.push_back('{rel: 1'b1, idx: 0, to: 1'b0, cyc: c + 11});
    repeat (3) @(negedge clk);

    // asynchronous reset while requester 5 owns the resource
    c = cyc;
    ifa.req = 8'b0010_0000;
    qa.push_back('{rel: 1'b0, idx: 5, to: 1'b0, cyc: c + 1});
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", int'(ifa.grant_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_grant", int'(ifa.grant), 0);
    chk("async_reset_valid", int'(ifa.grant_valid), 0);
    chk("async_reset_idx", int'(ifa.grant_idx), 0);
    chk("async_reset_timeout", int'(ifa.timeout), 0);
    @(negedge clk);
    @(negedge clk);
    ifa.req = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // HOLD_MAX=2, requesters 7 and 0 held high
    c = cyc;
    ifb.req = 8'b1000_0001;
    for (int t = 0; t < 4; t++) begin
`ifdef ROUND_ROBIN_EN
      s = (t % 2 == 0) ? 7 : 0;
`else
      s = 7;
`endif
      qb.push_back('{rel: 1'b0, idx: s, to: 1'b0, cyc: c + 1 + 4 * t});
      if (t < 3) qb.push_back('{rel: 1'b1, idx: 0, to: 1'b1, cyc: c + 3 + 4 * t});
    end
    repeat (14) @(negedge clk);
    ifb.req = '0;
    qb.push_back('{rel: 1'b1, idx: 0, to: 1'b0, cyc: c + 15});
    repeat (4) @(negedge clk);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
